// File: rtl/imply_stack.sv
// imply_stack: LIFO trail of variable assignments for the SAT solver datapath.
// Pushes come from conflict_detector or the decision unit. A backtrack request
// unwinds one entry per cycle down to and including the most recent decision.
// Each popped entry is presented on undo_* so the variable table can unassign
// it and the decision unit can flip the decision.
//
// Optional feature: define IMPLY_STACK_HWM_EN to add the max_count output
// (high-water mark of count).
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   push_en/var/val/decision   push request and entry payload
//   backtrack_start     single-cycle request to unwind to the last decision
//   undo_valid/var/val/is_decision   popped entry (registered)
//   backtrack_done      one-cycle pulse when the unwind completes
//   no_decision         with backtrack_done: stack emptied with no decision
//   busy, full, empty   status flags (registered)
//   count               occupied entries
//   decision_level      number of decision entries on the stack
//   max_count           high-water mark of count (IMPLY_STACK_HWM_EN only)
//   error               sticky; set on a dropped push
module imply_stack #(
  parameter int unsigned VAR_W   = 9,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LEVEL_W = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_en,
  input  logic [VAR_W-1:0]         push_var,
  input  logic                     push_val,
  input  logic                     push_decision,
  input  logic                     backtrack_start,
  output logic                     undo_valid,
  output logic [VAR_W-1:0]         undo_var,
  output logic                     undo_val,
  output logic                     undo_is_decision,
  output logic                     backtrack_done,
  output logic                     no_decision,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [LEVEL_W-1:0]       decision_level,
`ifdef IMPLY_STACK_HWM_EN
  output logic [$clog2(DEPTH):0]   max_count,
`endif
  output logic                     error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UNWIND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  typedef struct packed {
    logic [VAR_W-1:0] var_idx;
    logic             val;
    logic             dec;
  } entry_t;

  entry_t mem [DEPTH];

  logic [1:0]         state, state_n;
  logic [CW-1:0]      count_n;
  logic [LEVEL_W-1:0] level_n;
  logic               error_n;
  logic               undo_valid_n, undo_val_n, undo_dec_n;
  logic [VAR_W-1:0]   undo_var_n;
  logic               done_n, nodec_n;
  logic               wr_en;
  entry_t             wr_entry;
  entry_t             top;
`ifdef IMPLY_STACK_HWM_EN
  logic [CW-1:0]      max_n;
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    state_n      = state;
    count_n      = count;
    level_n      = decision_level;
    error_n      = error;
    undo_valid_n = 1'b0;
    undo_var_n   = undo_var;
    undo_val_n   = undo_val;
    undo_dec_n   = undo_is_decision;
    done_n       = 1'b0;
    nodec_n      = 1'b0;
    wr_en        = 1'b0;
    wr_entry     = '{var_idx: push_var, val: push_val, dec: push_decision};
    // Top of stack; when count is 0 this reads a stale slot that is never used.
    top          = mem[AW'(count - CW'(1))];

    case (state)
      IDLE: begin
        if (push_en) begin
          if (count != CW'(DEPTH)) begin
            wr_en   = 1'b1;
            count_n = count + CW'(1);
            if (push_decision) level_n = decision_level + LEVEL_W'(1);
          end else begin
            error_n = 1'b1;
          end
        end
        // A same-cycle push lands first, so it becomes the first entry popped.
        if (backtrack_start) state_n = UNWIND;
      end

      UNWIND: begin
        if (push_en) error_n = 1'b1;
        if (count == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
          nodec_n = 1'b1;
        end else begin
          undo_valid_n = 1'b1;
          undo_var_n   = top.var_idx;
          undo_val_n   = top.val;
          undo_dec_n   = top.dec;
          count_n      = count - CW'(1);
          if (top.dec) begin
            level_n = decision_level - LEVEL_W'(1);
            state_n = DONE;
            done_n  = 1'b1;
          end else if (count == CW'(1)) begin
            state_n = DONE;
            done_n  = 1'b1;
            nodec_n = 1'b1;
          end
        end
      end

      DONE: begin
        if (push_en) error_n = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

`ifdef IMPLY_STACK_HWM_EN
    max_n = max_count;
    if (wr_en && (count_n > max_count)) max_n = count_n;
`endif
  end

  // Stack storage; no reset needed since count gates every read.
  always_ff @(posedge clock) begin
    if (wr_en) mem[AW'(count)] <= wr_entry;
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      decision_level   <= '0;
      error            <= 1'b0;
      undo_valid       <= 1'b0;
      undo_var         <= '0;
      undo_val         <= 1'b0;
      undo_is_decision <= 1'b0;
      backtrack_done   <= 1'b0;
      no_decision      <= 1'b0;
      busy             <= 1'b0;
      full             <= 1'b0;
      empty            <= 1'b1;
`ifdef IMPLY_STACK_HWM_EN
      max_count        <= '0;
`endif
    end else begin
      state            <= state_n;
      count            <= count_n;
      decision_level   <= level_n;
      error            <= error_n;
      undo_valid       <= undo_valid_n;
      undo_var         <= undo_var_n;
      undo_val         <= undo_val_n;
      undo_is_decision <= undo_dec_n;
      backtrack_done   <= done_n;
      no_decision      <= nodec_n;
      busy             <= (state_n != IDLE);
      full             <= (count_n == CW'(DEPTH));
      empty            <= (count_n == '0);
`ifdef IMPLY_STACK_HWM_EN
      max_count        <= max_n;
`endif
    end
  end

endmodule

// File: tb/tb_imply_stack.sv
// tb_imply_stack: scoreboard bench for imply_stack. A queue-based stack model
// predicts the undo sequence of every backtrack; a monitor compares each
// presented undo/backtrack_done cycle against the expected-event queue.
module tb_imply_stack;

  localparam int VAR_W   = 9;
  localparam int DEPTH   = 512;
  localparam int LEVEL_W = 9;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               push_en = 1'b0;
  logic [VAR_W-1:0]   push_var = '0;
  logic               push_val = 1'b0;
  logic               push_decision = 1'b0;
  logic               backtrack_start = 1'b0;
  logic               undo_valid, undo_val, undo_is_decision;
  logic [VAR_W-1:0]   undo_var;
  logic               backtrack_done, no_decision, busy, full, empty, error;
  logic [CW-1:0]      count;
  logic [LEVEL_W-1:0] decision_level;
`ifdef IMPLY_STACK_HWM_EN
  logic [CW-1:0]      max_count;
`endif

  imply_stack #(.VAR_W(VAR_W), .DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
    .clock(clock), .reset(reset),
    .push_en(push_en), .push_var(push_var), .push_val(push_val),
    .push_decision(push_decision), .backtrack_start(backtrack_start),
    .undo_valid(undo_valid), .undo_var(undo_var), .undo_val(undo_val),
    .undo_is_decision(undo_is_decision), .backtrack_done(backtrack_done),
    .no_decision(no_decision), .busy(busy), .full(full), .empty(empty),
    .count(count), .decision_level(decision_level),
`ifdef IMPLY_STACK_HWM_EN
    .max_count(max_count),
`endif
    .error(error)
  );

  always #5 clock = ~clock;

  typedef struct { int v; int val; int dec; } ent_t;
  typedef struct { int uv; int v; int val; int dec; int done; int nod; } ev_t;

  ent_t stk[$];
  ev_t  exp_q[$];
  int   m_err = 0;
  int   m_hwm = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int m_level();
    int n = 0;
    foreach (stk[i]) if (stk[i].dec != 0) n++;
    return n;
  endfunction

  function automatic void m_push(input int v, input int val, input int dec);
    ent_t e;
    if (stk.size() < DEPTH) begin
      e.v = v; e.val = val; e.dec = dec;
      stk.push_back(e);
      if (stk.size() > m_hwm) m_hwm = stk.size();
    end else begin
      m_err = 1;
    end
  endfunction

  // Predicted unwind: pop to and including the latest decision.
  function automatic void m_unwind();
    ev_t  ev;
    ent_t e;
    bit   fin;
    if (stk.size() == 0) begin
      ev = '{uv: 0, v: 0, val: 0, dec: 0, done: 1, nod: 1};
      exp_q.push_back(ev);
      return;
    end
    do begin
      e   = stk.pop_back();
      fin = (e.dec != 0) || (stk.size() == 0);
      ev  = '{uv: 1, v: e.v, val: e.val, dec: e.dec, done: int'(fin),
              nod: int'(fin && e.dec == 0)};
      exp_q.push_back(ev);
    end while (!fin);
  endfunction

  // Monitor: every presented undo or done cycle must match the next event.
  always @(negedge clock) begin
    if (!reset && (undo_valid || backtrack_done)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_output: undo_valid=%0b backtrack_done=%0b, expected none",
                 undo_valid, backtrack_done);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("undo_valid", 32'(undo_valid), 32'(e.uv));
        if (e.uv != 0) begin
          check("undo_var", 32'(undo_var), 32'(e.v));
          check("undo_val", 32'(undo_val), 32'(e.val));
          check("undo_is_decision", 32'(undo_is_decision), 32'(e.dec));
        end
        check("backtrack_done", 32'(backtrack_done), 32'(e.done));
        check("no_decision", 32'(no_decision), 32'(e.nod));
      end
    end
  end

  task automatic check_status();
    check("count", 32'(count), 32'(stk.size()));
    check("decision_level", 32'(decision_level), 32'(m_level()));
    check("empty", 32'(empty), 32'(stk.size() == 0));
    check("full", 32'(full), 32'(stk.size() == DEPTH));
    check("error", 32'(error), 32'(m_err));
    check("busy", 32'(busy), 32'd0);
`ifdef IMPLY_STACK_HWM_EN
    check("max_count", 32'(max_count), 32'(m_hwm));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push_en = 1'b0;
    backtrack_start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    stk.delete();
    exp_q.delete();
    m_err = 0;
    m_hwm = 0;
    check("rst_undo_valid", 32'(undo_valid), 32'd0);
    check("rst_backtrack_done", 32'(backtrack_done), 32'd0);
    check("rst_no_decision", 32'(no_decision), 32'd0);
    check_status();
  endtask

  task automatic do_push(input int v, input int val, input int dec);
    push_var = VAR_W'(v);
    push_val = val[0];
    push_decision = dec[0];
    push_en = 1'b1;
    @(posedge clock);
    #1 push_en = 1'b0;
    m_push(v, val, dec);
  endtask

  // Backtrack, optionally with a same-cycle push and/or a push while unwinding.
  task automatic do_bt(input bit wp, input int v, input int val, input int dec, input bit busy_push);
    int k;
    if (wp) begin
      push_var = VAR_W'(v);
      push_val = val[0];
      push_decision = dec[0];
      push_en = 1'b1;
      m_push(v, val, dec);
    end
    m_unwind();
    backtrack_start = 1'b1;
    @(posedge clock);
    #1 backtrack_start = 1'b0;
    push_en = 1'b0;
    if (busy_push) begin
      push_var = VAR_W'($urandom_range(0, 511));
      push_decision = 1'b1;
      push_en = 1'b1;
    end
    @(posedge clock);
    #1 push_en = 1'b0;
    if (busy_push) m_err = 1;
    check("first_response_latency", 32'(undo_valid | backtrack_done), 32'd1);
    k = 0;
    while (!backtrack_done && k < DEPTH + 4) begin
      @(posedge clock);
      #1 k++;
    end
    if (!backtrack_done) check("backtrack_done_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    check("post_done_pulse_cleared", 32'(backtrack_done), 32'd0);
    check("post_undo_valid_cleared", 32'(undo_valid), 32'd0);
    check("post_no_decision_cleared", 32'(no_decision), 32'd0);
    check("expected_events_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_status();
  endtask

  initial begin
    // Directed: basic push / unwind to decision.
    do_reset();
    do_push(1, 0, 1);
    do_push(2, 1, 0);
    do_push(3, 1, 0);
    check_status();
    do_bt(0, 0, 0, 0, 0);
`ifdef IMPLY_STACK_HWM_EN
    check("hwm_after_first", 32'(max_count), 32'd3);
`endif

    // Implications only: empties the stack, reports no decision.
    do_push(5, 1, 0);
    do_push(6, 0, 0);
    do_bt(0, 0, 0, 0, 0);

    // Empty stack backtrack.
    do_bt(0, 0, 0, 0, 0);

    // Same-cycle push and backtrack: pushed entry pops first.
    do_push(7, 1, 1);
    do_push(8, 0, 0);
    do_bt(1, 9, 1, 0, 0);

    // Fill to capacity, then overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      do_push($urandom_range(0, 511), $urandom_range(0, 1), ($urandom_range(0, 15) == 0) ? 1 : 0);
    check_status();
    do_push(100, 1, 0);
    check_status();

    // Push while unwinding is dropped and flags error.
    do_reset();
    do_push(10, 1, 1);
    do_push(11, 0, 0);
    do_push(12, 1, 0);
    do_bt(0, 0, 0, 0, 1);

    // Reset in the middle of an unwind.
    do_reset();
    do_push(20, 0, 1);
    for (int i = 0; i < 5; i++) do_push(21 + i, i & 1, 0);
    backtrack_start = 1'b1;
    @(posedge clock);
    #1 backtrack_start = 1'b0;
    @(posedge clock);
    #1;
    check("mid_unwind_undo_valid", 32'(undo_valid), 32'd1);
    check("mid_unwind_undo_var", 32'(undo_var), 32'd25);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    stk.delete();
    exp_q.delete();
    m_err = 0;
    m_hwm = 0;
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_undo_valid", 32'(undo_valid), 32'd0);
    check("abort_backtrack_done", 32'(backtrack_done), 32'd0);
    check_status();

    // Randomized mix of pushes and backtracks.
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 7)
        do_push($urandom_range(0, 511), $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0);
      else if (op < 9)
        do_bt(0, 0, 0, 0, 0);
      else
        do_bt(1, $urandom_range(0, 511), $urandom_range(0, 1), $urandom_range(0, 1), 0);
    end
    check_status();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
